// File: rtl/pipeline_stall_flush_ctrl.sv
// Stall/flush/halt controller for the in-order pipeline front end.
// Owns PC and IF/ID write enables, bubble injection and debug halt.
module pipeline_stall_flush_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load_use_stall,
    input  logic                 i_branch_taken,
    input  logic                 i_halt_req,
    input  logic                 i_resume,
    input  logic                 i_clr_counts,
    output logic                 o_pc_write,
    output logic                 o_if_id_write,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_flush,
    output logic                 o_halted,
    output logic [CNT_WIDTH-1:0] o_stall_cycles,
    output logic [CNT_WIDTH-1:0] o_flush_events
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] drain_q, drain_d;
    logic       stall_inc, flush_inc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RUN;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_halted      = 1'b0;
        unique case (state_q)
            RUN: begin
                // branch beats stall; halt waits for a quiet cycle
                if (i_branch_taken) begin
                    o_pc_write    = 1'b1;
                    o_if_id_write = 1'b1;
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                    flush_inc     = 1'b1;
                end else if (i_load_use_stall) begin
                    o_id_ex_flush = 1'b1;
                    stall_inc     = 1'b1;
                end else if (i_halt_req) begin
                    o_id_ex_flush = 1'b1;
                    state_d       = DRAIN;
                    drain_d       = DRAIN_LOAD;
                end else begin
                    o_pc_write    = 1'b1;
                    o_if_id_write = 1'b1;
                end
            end
            DRAIN: begin
                o_id_ex_flush = 1'b1;
                drain_d       = drain_q - 4'd1;
                if (drain_q <= 4'd1) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                o_id_ex_flush = 1'b1;
                o_halted      = 1'b1;
                if (i_resume && !i_halt_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                drain_d = 4'd0;
            end
        endcase
        // reset forces every control output low, not just the state
        if (!i_rst_n) begin
            o_pc_write    = 1'b0;
            o_if_id_write = 1'b0;
            o_if_id_flush = 1'b0;
            o_id_ex_flush = 1'b0;
            o_halted      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cycles <= '0;
            o_flush_events <= '0;
        end else if (i_clr_counts) begin
            o_stall_cycles <= '0;
            o_flush_events <= '0;
        end else begin
            if (stall_inc && (o_stall_cycles != '1)) begin
                o_stall_cycles <= o_stall_cycles + 1'b1;
            end
            if (flush_inc && (o_flush_events != '1)) begin
                o_flush_events <= o_flush_events + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// Directed bench for pipeline_stall_flush_ctrl.
// Counters built 4 bits wide so saturation is reached in a few cycles.
module tb_pipeline_stall_flush_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          branch;
    logic          halt;
    logic          resume;
    logic          clr;
    logic          pc_write;
    logic          if_id_write;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          halted;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic [4:0]    ctl;

    int checks;
    int errors;

    localparam logic [4:0] C_RESET  = 5'b00000;
    localparam logic [4:0] C_RUN    = 5'b11000;
    localparam logic [4:0] C_BRANCH = 5'b11110;
    localparam logic [4:0] C_FREEZE = 5'b00010;
    localparam logic [4:0] C_HALTED = 5'b00011;

    pipeline_stall_flush_ctrl #(
        .DRAIN_CYCLES(2),
        .CNT_WIDTH(CW)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_load_use_stall(stall),
        .i_branch_taken  (branch),
        .i_halt_req      (halt),
        .i_resume        (resume),
        .i_clr_counts    (clr),
        .o_pc_write      (pc_write),
        .o_if_id_write   (if_id_write),
        .o_if_id_flush   (if_id_flush),
        .o_id_ex_flush   (id_ex_flush),
        .o_halted        (halted),
        .o_stall_cycles  (stall_cnt),
        .o_flush_events  (flush_cnt)
    );

    assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_flush, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs;
        stall  = 1'b0;
        branch = 1'b0;
        halt   = 1'b0;
        resume = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic clear_counts;
        @(negedge clk);
        idle_inputs();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ctl !== C_RESET) begin
            errors++;
            $display("FAIL reset_ctl got %b exp %b", ctl, C_RESET);
        end
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %h/%h exp 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", ctl, C_RUN);
        end
    endtask

    task automatic test_load_use;
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            #1;
            checks++;
            if (ctl !== C_FREEZE) begin
                errors++;
                $display("FAIL load_use_ctl[%0d] got %b exp %b", i, ctl, C_FREEZE);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL load_use_after got %b exp %b", ctl, C_RUN);
        end
        checks++;
        if (stall_cnt !== 4'd3 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL load_use_cnt got %h/%h exp 3/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_branch_priority;
        clear_counts();
        branch = 1'b1;
        stall  = 1'b1;
        #1;
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++;
            $display("FAIL branch_prio_ctl got %b exp %b", ctl, C_BRANCH);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL branch_prio_cnt got %h/%h exp 1/0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_halt_deferred;
        logic [4:0] exp_seq [5];
        exp_seq = '{C_FREEZE, C_FREEZE, C_FREEZE, C_FREEZE, C_HALTED};
        clear_counts();
        // cycle 0 stalled, 1 accepts, 2-3 drain with branch ignored, 4 halted
        for (int i = 0; i < 5; i++) begin
            halt   = 1'b1;
            stall  = (i == 0);
            branch = (i == 2 || i == 3);
            #1;
            checks++;
            if (ctl !== exp_seq[i]) begin
                errors++;
                $display("FAIL halt_seq[%0d] got %b exp %b", i, ctl, exp_seq[i]);
            end
            @(negedge clk);
        end
        branch = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 4'd1 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL halt_cnt got %h/%h exp 1/0", stall_cnt, flush_cnt);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        #1;
        checks++;
        if (ctl !== C_HALTED) begin
            errors++;
            $display("FAIL resume_with_req got %b exp %b", ctl, C_HALTED);
        end
        halt = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== C_HALTED) begin
            errors++;
            $display("FAIL halt_hold got %b exp %b", ctl, C_HALTED);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL resume_run got %b exp %b", ctl, C_RUN);
        end
    endtask

    task automatic test_resume_ignored;
        @(negedge clk);
        idle_inputs();
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL resume_in_run got %b exp %b", ctl, C_RUN);
        end
    endtask

    task automatic test_saturation;
        clear_counts();
        stall = 1'b1;
        repeat (14) @(negedge clk);
        stall = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 4'hE) begin
            errors++;
            $display("FAIL sat_pre got %h exp e", stall_cnt);
        end
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_stall got %h exp f", stall_cnt);
        end
        branch = 1'b1;
        repeat (17) @(negedge clk);
        branch = 1'b0;
        #1;
        checks++;
        if (flush_cnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_flush got %h exp f", flush_cnt);
        end
        stall = 1'b1;
        clr   = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clr_prio got %h/%h exp 0/0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset_mid_drain;
        @(negedge clk);
        idle_inputs();
        branch = 1'b1;
        @(negedge clk);
        branch = 1'b0;
        halt   = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== C_FREEZE) begin
            errors++;
            $display("FAIL drain_pre got %b exp %b", ctl, C_FREEZE);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RESET || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_drain_rst got %b/%h exp %b/0", ctl, flush_cnt, C_RESET);
        end
        halt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL rst_release got %b exp %b", ctl, C_RUN);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL rst_run_hold got %b exp %b", ctl, C_RUN);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch_priority();
        test_halt_deferred();
        test_resume_ignored();
        test_saturation();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_flush_ctrl.md
PIPELINE_STALL_FLUSH_CTRL -- requirements
Module: pipeline_stall_flush_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2, number of drain cycles between halt acceptance and halted state (range 1..15).
REQ-002 Parameter CNT_WIDTH, default 16, width of both event counters.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_load_use_stall  input  1  load-use hazard request from the hazard detection unit.
REQ-006 i_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-007 i_halt_req  input  1  level halt request from debug unit; held high until o_halted=1.
REQ-008 i_resume  input  1  single-cycle resume pulse from debug unit.
REQ-009 i_clr_counts  input  1  synchronous clear of both counters.
REQ-010 o_pc_write  output  1  PC register write enable.
REQ-011 o_if_id_write  output  1  IF/ID register write enable.
REQ-012 o_if_id_flush  output  1  load NOP into IF/ID at next edge.
REQ-013 o_id_ex_flush  output  1  load bubble (all control zero) into ID/EX at next edge.
REQ-014 o_halted  output  1  pipeline drained and frozen.
REQ-015 o_stall_cycles  output  CNT_WIDTH  count of applied load-use stall cycles.
REQ-016 o_flush_events  output  CNT_WIDTH  count of applied branch flushes.

Function
REQ-017 FSM states SHALL be RUN, DRAIN, HALTED; control outputs combinational from state and inputs, zero-latency.
REQ-018 RUN, no event: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0.
REQ-019 RUN, i_branch_taken=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1; branch SHALL take priority over a simultaneous load-use stall.
REQ-020 RUN, i_load_use_stall=1 and no branch: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1.
REQ-021 RUN, i_halt_req=1 SHALL be accepted only when i_branch_taken=0 and i_load_use_stall=0; otherwise deferred, branch/stall behaviour applies, retried next cycle.
REQ-022 Acceptance cycle: pc_write=0, if_id_write=0, id_ex_flush=1; next state DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-023 DRAIN: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1; counter decrements each cycle; transition to HALTED on the edge where counter reaches 0 (exactly DRAIN_CYCLES cycles in DRAIN).
REQ-024 HALTED: same freeze outputs as DRAIN, o_halted=1; o_halted SHALL be 0 in all other states.
REQ-025 i_branch_taken and i_load_use_stall SHALL be ignored in DRAIN and HALTED (no counter increments).
REQ-026 HALTED, i_resume=1 with i_halt_req=0: next state RUN; resume with i_halt_req=1 ignored; i_resume outside HALTED ignored.
REQ-027 Instruction held in IF/ID during halt SHALL issue normally in the first RUN cycle after resume.
REQ-028 o_stall_cycles increments by 1 each RUN cycle where REQ-020 applies; o_flush_events increments by 1 each RUN cycle where REQ-019 applies.
REQ-029 Counters SHALL saturate at all-ones (no wrap).
REQ-030 i_clr_counts=1 SHALL zero both counters at next edge, taking priority over a same-cycle increment; allowed in any state.

Reset
REQ-031 While i_rst_n=0: state RUN, drain counter 0, both counters 0, o_pc_write=0, o_if_id_write=0, o_if_id_flush=0, o_id_ex_flush=0, o_halted=0.
REQ-032 Reset assertion in any state (including mid-DRAIN) SHALL take effect immediately; after deassertion first cycle is RUN with REQ-018 outputs.

Verification
REQ-033 Load-use stall high 3 cycles in RUN -> pc_write=if_id_write=0, id_ex_flush=1 each cycle; o_stall_cycles=3.
REQ-034 Branch and load-use high same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; o_flush_events=1, o_stall_cycles=0.
REQ-035 Halt with load-use high 1 cycle -> deferred 1 cycle, accepted next, exactly 2 DRAIN cycles, o_halted=1 on 4th cycle after request; resume -> RUN next cycle.
REQ-036 Counter preloaded to 0xFFFE, 3 stall cycles -> holds 0xFFFF; i_clr_counts with stall same cycle -> 0.
REQ-037 Reset asserted mid-DRAIN -> outputs immediately at reset values; after release, RUN with pc_write=1, o_halted=0.
REQ-038 i_resume in HALTED with i_halt_req still 1 -> remains HALTED; resume after request drops -> RUN.
